// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - operation encodings presented on the op port
//   - IDLE/RUN state encoding
//   - small helper for two's-complement magnitude
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Absolute value of a 32-bit two's-complement number. 0x80000000 maps to
    // itself, which is the correct magnitude when read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// A MULT/MULTU/DIV/DIVU accepted in IDLE computes its 64-bit result on the
// start edge, parks it in a pending register and exposes busy for a fixed
// number of cycles; HI/LO are written on the final busy edge. MTHI/MTLO write
// HI/LO directly on the start edge with no busy time.
//
// Ports
//   clk    in   sole clock, rising edge
//   reset  in   asynchronous, active-high reset
//   start  in   instruction valid in E stage this cycle
//   op     in   [2:0] operation select (mdu_op_e)
//   a      in   [31:0] rs operand
//   b      in   [31:0] rt operand
//   busy   out  multi-cycle operation in progress
//   hi     out  [31:0] architectural HI
//   lo     out  [31:0] architectural LO
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | ready; accepts MDU ops and MTHI/MTLO
// ST_RUN  | counting down; start ignored, HI/LO frozen
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      pend_q;
    logic             pend_wr_q;

    logic [63:0]      res_d;
    logic             wr_d;
    logic signed [63:0] sa64, sb64;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      a_mag, b_mag;
    logic [31:0]      uq, ur, mq, mr, sq, sr;

    // Result path sees live a/b only at the start edge; during RUN only the
    // pending register feeds HI/LO.
    always_comb begin
        sa64   = signed'({{32{a[31]}}, a});
        sb64   = signed'({{32{b[31]}}, b});
        prod_s = sa64 * sb64;
        prod_u = {32'd0, a} * {32'd0, b};
        a_mag  = mag32(a);
        b_mag  = mag32(b);
        uq     = '0;
        ur     = '0;
        mq     = '0;
        mr     = '0;
        if (b != 32'd0) begin
            uq = a / b;
            ur = a % b;
            mq = a_mag / b_mag;
            mr = a_mag % b_mag;
        end
        // Signed divide via magnitudes avoids the -2^31 / -1 overflow case:
        // magnitude 0x80000000 / 1 gives 0x80000000, sign stays positive.
        sq = (a[31] ^ b[31]) ? (~mq + 32'd1) : mq;
        sr = a[31] ? (~mr + 32'd1) : mr;

        res_d = '0;
        wr_d  = 1'b0;
        case (mdu_op_e'(op))
            OP_MULT:  begin res_d = prod_s;   wr_d = 1'b1;           end
            OP_MULTU: begin res_d = prod_u;   wr_d = 1'b1;           end
            OP_DIV:   begin res_d = {sr, sq}; wr_d = (b != 32'd0);   end
            OP_DIVU:  begin res_d = {ur, uq}; wr_d = (b != 32'd0);   end
            default:  begin res_d = '0;       wr_d = 1'b0;           end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (mdu_op_e'(op))
                            OP_MULT, OP_MULTU: begin
                                pend_q    <= res_d;
                                pend_wr_q <= wr_d;
                                cnt_q     <= CNT_W'(MUL_CYC);
                                state_q   <= ST_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_q    <= res_d;
                                pend_wr_q <= wr_d;
                                cnt_q     <= CNT_W'(DIV_CYC);
                                state_q   <= ST_RUN;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        // Divide-by-zero leaves pend_wr_q clear so HI/LO keep their values.
                        if (pend_wr_q) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
